dp_ram_arbiter: RTL and testbench
=================================

Name: dp_ram_arbiter

Overview:
Two-requester round-robin arbiter that shares port A of the on-chip dual-port RAM between the core data port (requester 0) and a secondary master such as a debug or loader unit (requester 1). It accepts valid/ready requests on each side and issues exactly one single-cycle access to the RAM per grant. It then waits for the RAM's registered ready and routes ready and read data back to the granted requester. Port B of the RAM (instruction fetch) is not touched.

Parameters:
ADDR_WIDTH, `RISCV_ADDR_WIDTH, byte-address width on all address ports
DATA_WIDTH, `RISCV_WORD_WIDTH, data width on all data ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
r0_valid_i  input  1  requester 0 request; held until r0_ready_o
r0_ready_o  output  1  requester 0 access complete (one-cycle pulse)
r0_addr_i  input  ADDR_WIDTH  requester 0 byte address
r0_wdata_i  input  DATA_WIDTH  requester 0 write data
r0_we_i  input  4  requester 0 byte write enables
r0_rdata_o  output  DATA_WIDTH  requester 0 read data, valid with r0_ready_o
r1_valid_i, r1_ready_o, r1_addr_i, r1_wdata_i, r1_we_i, r1_rdata_o: identical set for requester 1
m_valid_o  output  1  RAM port A valid
m_ready_i  input  1  RAM port A ready (registered, one cycle after m_valid_o)
m_addr_o  output  ADDR_WIDTH  RAM address
m_wdata_o  output  DATA_WIDTH  RAM write data
m_we_o  output  4  RAM byte enables
m_rdata_i  input  DATA_WIDTH  RAM read data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- State machine: IDLE, BUSY. The registers are state, grant (1 bit) and last (1 bit, the last-served requester).
- Reset: state=IDLE, grant=0, last=1, so requester 0 wins the first tie. All outputs are 0 while in IDLE with no valid request.
- IDLE: the winner is selected combinationally.
  - Only one valid: that requester wins.
  - Both valid: the requester that is not `last` wins.
- IDLE, any valid present:
  - m_valid_o=1 for exactly one cycle.
  - m_addr_o, m_wdata_o and m_we_o are muxed from the winner.
  - grant<=winner; state<=BUSY.
- IDLE, no valid: m_valid_o=0, m_addr_o=0, m_wdata_o=0, m_we_o=0.
- BUSY:
  - m_valid_o=0 and m_we_o=0; no further write can be issued.
  - m_addr_o and m_wdata_o are don't-care.
  - On m_ready_i=1: rN_ready_o=1 for the granted N, rN_rdata_o=m_rdata_i combinationally, last<=grant, state<=IDLE.
  - Without m_ready_i, stay in BUSY indefinitely.
- Non-granted requester: ready_o=0 and rdata_o=0 at all times.
- Latency: an uncontended access completes 2 cycles after valid is first seen (issue cycle plus ready cycle). Throughput is one access per 2 cycles.
- Requester rule: a requester must drop valid, or present a new request, in the cycle after it sees ready. The arbiter re-samples valid in IDLE.
- Simultaneous ready and a new request from the other requester: the new request is not considered until the following IDLE cycle.
- m_ready_i seen in IDLE (stale ready after a reset mid-access): ignored, no ready pulse is generated.
- Reset while BUSY: state returns to IDLE and the in-flight completion is dropped. Both requesters must re-issue.
- Starvation bound: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
Macro: ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], which counts cycles where any requester has valid=1 but is not being issued or completed (waiting for its grant).
  - Increments by 1 per such cycle and wraps from 0xFFFFFFFF to 0.
  - Reset value 0.
- When undefined: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then r0_valid with addr=0x10, we=0xF, wdata=0xDEADBEEF -> m_valid_o pulses one cycle with those values; r0_ready_o is 1 on cycle 2; a later r0 read of 0x10 returns 0xDEADBEEF.
- r0 and r1 valid in the same cycle, both reads -> r0 is served first (cycles 1-2), then r1 (cycles 3-4). r1_ready_o is never asserted during r0's grant.
- Both requesters continuously valid for 8 accesses -> grants alternate 0,1,0,1,...; each requester gets ready exactly 4 times.
- Byte write from r1: we=0x2, wdata=0x0000AB00 to a word holding 0x11223344 -> a read returns 0x1122AB44.
- Assert rst in the BUSY cycle; RAM ready arrives in the next cycle -> no rN_ready_o pulse, state is IDLE, and the next request issues normally.
- ARB_STALL_CNT_EN defined, both requesters valid for one access each -> stall_cnt_o=2 (r1 waits 2 cycles).

Source files
------------

// File: rtl/dp_ram_arbiter_if.sv
// Bus bundle between the two requesters, the port-A arbiter and RAM port A.
// slave = arbiter view, master = requesters/RAM view.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

interface dp_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `RISCV_WORD_WIDTH
);
  localparam int unsigned WE_WIDTH = 4;

  logic                  r0_valid_i;
  logic                  r0_ready_o;
  logic [ADDR_WIDTH-1:0] r0_addr_i;
  logic [DATA_WIDTH-1:0] r0_wdata_i;
  logic [WE_WIDTH-1:0]   r0_we_i;
  logic [DATA_WIDTH-1:0] r0_rdata_o;

  logic                  r1_valid_i;
  logic                  r1_ready_o;
  logic [ADDR_WIDTH-1:0] r1_addr_i;
  logic [DATA_WIDTH-1:0] r1_wdata_i;
  logic [WE_WIDTH-1:0]   r1_we_i;
  logic [DATA_WIDTH-1:0] r1_rdata_o;

  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic [WE_WIDTH-1:0]   m_we_o;
  logic [DATA_WIDTH-1:0] m_rdata_i;

  modport slave (
    input  r0_valid_i, r0_addr_i, r0_wdata_i, r0_we_i,
    output r0_ready_o, r0_rdata_o,
    input  r1_valid_i, r1_addr_i, r1_wdata_i, r1_we_i,
    output r1_ready_o, r1_rdata_o,
    output m_valid_o, m_addr_o, m_wdata_o, m_we_o,
    input  m_ready_i, m_rdata_i
  );

  modport master (
    output r0_valid_i, r0_addr_i, r0_wdata_i, r0_we_i,
    input  r0_ready_o, r0_rdata_o,
    output r1_valid_i, r1_addr_i, r1_wdata_i, r1_we_i,
    input  r1_ready_o, r1_rdata_o,
    input  m_valid_o, m_addr_o, m_wdata_o, m_we_o,
    output m_ready_i, m_rdata_i
  );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing RAM port A between two valid/ready requesters.
// Optional ARB_STALL_CNT_EN adds stall_cnt_o, a count of cycles a requester waits for grant.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module dp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `RISCV_WORD_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  dp_ram_arbiter_if.slave     bus
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int unsigned WE_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;

  logic                  any_valid_c;
  logic                  winner_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic [WE_WIDTH-1:0]   sel_we_c;

  // Winner: a lone requester wins; on a tie the one not served last wins.
  always_comb begin : winner_sel
    any_valid_c = bus.r0_valid_i | bus.r1_valid_i;
    winner_c    = 1'b0;
    if (bus.r0_valid_i && bus.r1_valid_i) begin
      winner_c = ~last_q;
    end else if (bus.r1_valid_i) begin
      winner_c = 1'b1;
    end
  end

  always_comb begin : req_mux
    sel_addr_c  = bus.r0_addr_i;
    sel_wdata_c = bus.r0_wdata_i;
    sel_we_c    = bus.r0_we_i;
    if (winner_c) begin
      sel_addr_c  = bus.r1_addr_i;
      sel_wdata_c = bus.r1_wdata_i;
      sel_we_c    = bus.r1_we_i;
    end
  end

  // State register; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          grant_d = winner_c;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ready_i) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A ready seen in IDLE is stale (reset mid-access) and produces no pulse.
  always_comb begin : out_logic
    bus.m_valid_o  = 1'b0;
    bus.m_addr_o   = '0;
    bus.m_wdata_o  = '0;
    bus.m_we_o     = '0;
    bus.r0_ready_o = 1'b0;
    bus.r0_rdata_o = '0;
    bus.r1_ready_o = 1'b0;
    bus.r1_rdata_o = '0;
    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          bus.m_valid_o = 1'b1;
          bus.m_addr_o  = sel_addr_c;
          bus.m_wdata_o = sel_wdata_c;
          bus.m_we_o    = sel_we_c;
        end
      end
      BUSY: begin
        if (bus.m_ready_i) begin
          if (grant_q) begin
            bus.r1_ready_o = 1'b1;
            bus.r1_rdata_o = bus.m_rdata_i;
          end else begin
            bus.r0_ready_o = 1'b1;
            bus.r0_rdata_o = bus.m_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef ARB_STALL_CNT_EN
  logic wait0_c, wait1_c;

  // A requester is waiting when valid but neither being issued nor holding the grant.
  always_comb begin : stall_detect
    wait0_c = bus.r0_valid_i &&
              !(((state_q == IDLE) && !winner_c) || ((state_q == BUSY) && !grant_q));
    wait1_c = bus.r1_valid_i &&
              !(((state_q == IDLE) && winner_c) || ((state_q == BUSY) && grant_q));
  end

  always_ff @(posedge clk) begin : stall_counter
    if (rst) begin
      stall_cnt_o <= 32'd0;
    end else if (wait0_c || wait1_c) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Scoreboard bench for dp_ram_arbiter with a behavioural RAM on port A.
// Define ARB_STALL_CNT_EN to also cover the stall counter.
module tb_dp_ram_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } req_t;

  bit clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  dp_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  req_t        rq0[$], rq1[$];
  logic [31:0] eq0[$], eq1[$];
  bit          ack0 = 1'b0, ack1 = 1'b0;
  bit [31:0]   ref_mem [256];

  // Behavioural RAM: write-through, ready and data ram_lat cycles after valid.
  bit [31:0]   ram_mem [256];
  int          ram_lat = 1;
  int          pend = 0;
  logic [31:0] pend_data;

  always @(posedge clk) begin
    logic [31:0] w;
    bus.m_ready_i <= 1'b0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        bus.m_ready_i <= 1'b1;
        bus.m_rdata_i <= pend_data;
      end
    end
    if (bus.m_valid_o) begin
      w = ram_mem[bus.m_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.m_we_o[b]) w[8*b +: 8] = bus.m_wdata_o[8*b +: 8];
      ram_mem[bus.m_addr_o[9:2]] = w;
      if (ram_lat <= 1) begin
        bus.m_ready_i <= 1'b1;
        bus.m_rdata_i <= w;
      end else begin
        pend      <= ram_lat - 1;
        pend_data <= w;
      end
    end
  end

  // Scoreboard: every ready pulse pops that requester's expected read data.
  always @(negedge clk) begin
    logic [31:0] e;
    ack0 = bus.r0_ready_o;
    ack1 = bus.r1_ready_o;
    if (bus.r0_ready_o) begin
      vectors++;
      if (eq0.size() == 0) begin
        miscompares++;
        $display("FAIL sb_r0: unexpected ready, rdata=%h expected no ready", bus.r0_rdata_o);
      end else begin
        e = eq0.pop_front();
        if (bus.r0_rdata_o !== e) begin
          miscompares++;
          $display("FAIL sb_r0: rdata=%h expected %h", bus.r0_rdata_o, e);
        end
      end
    end
    if (bus.r1_ready_o) begin
      vectors++;
      if (eq1.size() == 0) begin
        miscompares++;
        $display("FAIL sb_r1: unexpected ready, rdata=%h expected no ready", bus.r1_rdata_o);
      end else begin
        e = eq1.pop_front();
        if (bus.r1_rdata_o !== e) begin
          miscompares++;
          $display("FAIL sb_r1: rdata=%h expected %h", bus.r1_rdata_o, e);
        end
      end
    end
  end

  task automatic enqueue(input int n, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we);
    logic [31:0] w;
    req_t r;
    w = ref_mem[a[9:2]];
    for (int b = 0; b < 4; b++)
      if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[a[9:2]] = w;
    r.addr = a; r.wdata = wd; r.we = we;
    if (n == 0) begin rq0.push_back(r); eq0.push_back(w); end
    else        begin rq1.push_back(r); eq1.push_back(w); end
  endtask

  // Advance one clock, retire acknowledged requests, present queue heads.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (ack0 && rq0.size() != 0) rq0.delete(0);
    if (ack1 && rq1.size() != 0) rq1.delete(0);
    ack0 = 1'b0;
    ack1 = 1'b0;
    bus.r0_valid_i = (rq0.size() != 0);
    bus.r0_addr_i  = (rq0.size() != 0) ? rq0[0].addr  : 32'd0;
    bus.r0_wdata_i = (rq0.size() != 0) ? rq0[0].wdata : 32'd0;
    bus.r0_we_i    = (rq0.size() != 0) ? rq0[0].we    : 4'd0;
    bus.r1_valid_i = (rq1.size() != 0);
    bus.r1_addr_i  = (rq1.size() != 0) ? rq1[0].addr  : 32'd0;
    bus.r1_wdata_i = (rq1.size() != 0) ? rq1[0].wdata : 32'd0;
    bus.r1_we_i    = (rq1.size() != 0) ? rq1[0].we    : 4'd0;
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((rq0.size() + rq1.size() + eq0.size() + eq1.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    vectors++;
    if ((rq0.size() + rq1.size() + eq0.size() + eq1.size()) != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d requests outstanding after %0d cycles, expected 0",
               name, eq0.size() + eq1.size(), budget);
      rq0.delete(); rq1.delete(); eq0.delete(); eq1.delete();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_addr_o, bus.m_wdata_o, bus.m_we_o} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_m: valid=%b addr=%h wdata=%h we=%h expected all 0",
               bus.m_valid_o, bus.m_addr_o, bus.m_wdata_o, bus.m_we_o);
    end
    vectors++;
    if ({bus.r0_ready_o, bus.r0_rdata_o, bus.r1_ready_o, bus.r1_rdata_o} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_r: r0 ready=%b rdata=%h r1 ready=%b rdata=%h expected all 0",
               bus.r0_ready_o, bus.r0_rdata_o, bus.r1_ready_o, bus.r1_rdata_o);
    end
  endtask

  task automatic test_single_write();
    enqueue(0, 32'h10, 32'hDEADBEEF, 4'hF);
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_addr_o, bus.m_wdata_o, bus.m_we_o, bus.r0_ready_o} !==
        {1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL issue_wr: valid=%b addr=%h wdata=%h we=%h rdy=%b expected 1 10 deadbeef f 0",
               bus.m_valid_o, bus.m_addr_o, bus.m_wdata_o, bus.m_we_o, bus.r0_ready_o);
    end
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_we_o, bus.r0_ready_o, bus.r1_ready_o} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ready_wr: m_valid=%b m_we=%h r0_ready=%b r1_ready=%b expected 0 0 1 0",
               bus.m_valid_o, bus.m_we_o, bus.r0_ready_o, bus.r1_ready_o);
    end
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.r0_ready_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL after_wr: m_valid=%b r0_ready=%b expected 0 0", bus.m_valid_o, bus.r0_ready_o);
    end
    enqueue(0, 32'h10, 32'h0, 4'h0);
    drain("single_rd", 10);
  endtask

  task automatic test_contention();
    enqueue(0, 32'h20, 32'hA5A50001, 4'hF);
    drain("preload0", 10);
    enqueue(1, 32'h24, 32'h5A5A0002, 4'hF);
    drain("preload1", 10);
    pulse_reset();
    enqueue(0, 32'h20, 32'h0, 4'h0);
    enqueue(1, 32'h24, 32'h0, 4'h0);
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_addr_o, bus.r1_ready_o} !== {1'b1, 32'h20, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_c1: valid=%b addr=%h r1_ready=%b expected 1 20 0",
               bus.m_valid_o, bus.m_addr_o, bus.r1_ready_o);
    end
    cycle();
    vectors++;
    if ({bus.r0_ready_o, bus.r1_ready_o, bus.r1_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL tie_c2: r0_ready=%b r1_ready=%b r1_rdata=%h expected 1 0 0",
               bus.r0_ready_o, bus.r1_ready_o, bus.r1_rdata_o);
    end
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_addr_o, bus.r0_ready_o} !== {1'b1, 32'h24, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_c3: valid=%b addr=%h r0_ready=%b expected 1 24 0",
               bus.m_valid_o, bus.m_addr_o, bus.r0_ready_o);
    end
    cycle();
    vectors++;
    if ({bus.r0_ready_o, bus.r1_ready_o, bus.r0_rdata_o} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL tie_c4: r0_ready=%b r1_ready=%b r0_rdata=%h expected 0 1 0",
               bus.r0_ready_o, bus.r1_ready_o, bus.r0_rdata_o);
    end
    drain("contention", 10);
  endtask

  task automatic test_back_to_back();
    int issues = 0, rdy0 = 0, rdy1 = 0;
    for (int i = 0; i < 4; i++) begin
      enqueue(0, 32'h100 + 32'(4 * i), 32'h0A000000 + 32'(i), (i % 2 == 0) ? 4'hF : 4'h0);
      enqueue(1, 32'h200 + 32'(4 * i), 32'h0B000000 + 32'(i), (i % 2 == 1) ? 4'hF : 4'h0);
    end
    for (int c = 0; c < 40 && (rq0.size() + rq1.size()) != 0; c++) begin
      cycle();
      if (bus.r0_ready_o) rdy0++;
      if (bus.r1_ready_o) rdy1++;
      if (bus.m_valid_o) begin
        vectors++;
        if (32'(bus.m_addr_o[9]) !== 32'(issues % 2)) begin
          miscompares++;
          $display("FAIL alternate: issue %0d went to r%0d, expected r%0d",
                   issues, bus.m_addr_o[9], issues % 2);
        end
        issues++;
      end
    end
    vectors++;
    if (issues != 8 || rdy0 != 4 || rdy1 != 4) begin
      miscompares++;
      $display("FAIL alt_counts: issues=%0d r0_ready=%0d r1_ready=%0d expected 8 4 4",
               issues, rdy0, rdy1);
    end
    drain("back_to_back", 10);
  endtask

  task automatic test_byte_write();
    logic [31:0] last_rd = 32'h0;
    enqueue(1, 32'h40, 32'h11223344, 4'hF);
    enqueue(1, 32'h40, 32'h0000AB00, 4'h2);
    enqueue(1, 32'h40, 32'h0, 4'h0);
    for (int c = 0; c < 20 && rq1.size() != 0; c++) begin
      cycle();
      if (bus.r1_ready_o) last_rd = bus.r1_rdata_o;
    end
    vectors++;
    if (last_rd !== 32'h1122AB44) begin
      miscompares++;
      $display("FAIL byte_write: read %h expected 1122ab44", last_rd);
    end
    drain("byte_write", 10);
  endtask

  task automatic test_reset_busy();
    ram_lat = 2;
    enqueue(0, 32'h10, 32'h0, 4'h0);
    cycle();
    vectors++;
    if (bus.m_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rb_issue: m_valid=%b expected 1", bus.m_valid_o);
    end
    rq0.delete();
    eq0.delete();
    rst = 1'b1;
    cycle();
    vectors++;
    if ({bus.r0_ready_o, bus.r1_ready_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL rb_busy: r0_ready=%b r1_ready=%b expected 0 0", bus.r0_ready_o, bus.r1_ready_o);
    end
    rst = 1'b0;
    cycle();
    vectors++;
    if ({bus.r0_ready_o, bus.r1_ready_o, bus.m_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL rb_stale: r0_ready=%b r1_ready=%b m_valid=%b expected 0 0 0",
               bus.r0_ready_o, bus.r1_ready_o, bus.m_valid_o);
    end
    ram_lat = 1;
    enqueue(1, 32'h24, 32'h0, 4'h0);
    cycle();
    vectors++;
    if ({bus.m_valid_o, bus.m_addr_o} !== {1'b1, 32'h24}) begin
      miscompares++;
      $display("FAIL rb_reissue: valid=%b addr=%h expected 1 24", bus.m_valid_o, bus.m_addr_o);
    end
    cycle();
    vectors++;
    if (bus.r1_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rb_complete: r1_ready=%b expected 1", bus.r1_ready_o);
    end
    drain("reset_busy", 10);
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    pulse_reset();
    cycle();
    vectors++;
    if (stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL stall_reset: stall_cnt=%0d expected 0", stall_cnt_o);
    end
    enqueue(0, 32'h20, 32'h0, 4'h0);
    enqueue(1, 32'h24, 32'h0, 4'h0);
    drain("stall", 12);
    cycle();
    vectors++;
    if (stall_cnt_o !== 32'd2) begin
      miscompares++;
      $display("FAIL stall_cnt: stall_cnt=%0d expected 2", stall_cnt_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.r0_valid_i = 1'b0; bus.r0_addr_i = '0; bus.r0_wdata_i = '0; bus.r0_we_i = '0;
    bus.r1_valid_i = 1'b0; bus.r1_addr_i = '0; bus.r1_wdata_i = '0; bus.r1_we_i = '0;
    bus.m_ready_i  = 1'b0;
    bus.m_rdata_i  = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_byte_write();
    test_reset_busy();
`ifdef ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
